// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: two-requester round-robin arbiter in front of a single
// register-file write port. One accepted write is registered and presented
// on the following cycle; register 31 is accepted but never written.
module regwrite_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              valid_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              ready_a,
    input  logic              valid_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              ready_b,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic [7:0]        conflicts
);

    // Writes to the all-ones index are swallowed: accepted, but no enable.
    localparam logic [ADDR_W-1:0] REG_DISCARD = '1;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

    pri_t              pri_p1;
    logic              vld_p1;
    logic [ADDR_W-1:0] wreg_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic [7:0]        conflicts_p1;
    logic              grant_a;
    logic              grant_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Saturating 8-bit increment: sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Grant decision: single requester wins outright, contention goes to the pointer.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset && !stall) begin
            if (valid_a && valid_b) begin
                grant_a = (pri_p1 == PRI_A);
                grant_b = (pri_p1 == PRI_B);
            end else begin
                grant_a = valid_a;
                grant_b = valid_b;
            end
        end
    end

    assign ready_a  = grant_a;
    assign ready_b  = grant_b;
    assign sel_addr = grant_b ? addr_b : addr_a;
    assign sel_data = grant_b ? data_b : data_a;

    // ---- stage p0 -> p1: accepted write and arbitration state ----

    // Control: output valid, priority pointer and contention counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1       <= 1'b0;
            pri_p1       <= PRI_A;
            conflicts_p1 <= 8'd0;
        end else begin
            vld_p1 <= grant_a || grant_b;
            if (grant_a) begin
                pri_p1 <= PRI_B;
            end else if (grant_b) begin
                pri_p1 <= PRI_A;
            end
            if (valid_a && valid_b && !stall) begin
                conflicts_p1 <= sat_inc(conflicts_p1);
            end
        end
    end

    // Data: capture the granted index/data; hold otherwise (cleared on reset).
    always_ff @(posedge clk) begin
        if (reset) begin
            wreg_p1  <= '0;
            wdata_p1 <= '0;
        end else if (grant_a || grant_b) begin
            wreg_p1  <= sel_addr;
            wdata_p1 <= sel_data;
        end
    end

    // Reset also masks the enable combinationally so a write captured just
    // before reset never reaches the register file.
    assign RegWrite      = vld_p1 && (wreg_p1 != REG_DISCARD) && !reset;
    assign WriteRegister = wreg_p1;
    assign WriteData     = wdata_p1;
    assign conflicts     = conflicts_p1;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the arbiter.
module tb_regwrite_arbiter;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        valid_a;
    logic [4:0]  addr_a;
    logic [63:0] data_a;
    logic        ready_a;
    logic        valid_b;
    logic [4:0]  addr_b;
    logic [63:0] data_b;
    logic        ready_b;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [7:0]  conflicts;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    // model state
    int          m_ptr  = 0;      // 0 = A has priority, 1 = B
    bit          m_we   = 0;
    logic [4:0]  m_addr = '0;
    logic [63:0] m_data = '0;
    int          m_conf = 0;
    bit          e_a;
    bit          e_b;

    regwrite_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .valid_a(valid_a), .addr_a(addr_a), .data_a(data_a), .ready_a(ready_a),
        .valid_b(valid_b), .addr_b(addr_b), .data_b(data_b), .ready_b(ready_b),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .conflicts(conflicts)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: predict this cycle's outputs from the model, compare, then advance.
    always @(negedge clk) begin
        #2;
        e_a = 0;
        e_b = 0;
        if (!reset && !stall) begin
            if (valid_a && valid_b) begin
                e_a = (m_ptr == 0);
                e_b = (m_ptr == 1);
            end else begin
                e_a = valid_a;
                e_b = valid_b;
            end
        end
        if (check_en) begin
            chk("m_ready_a", ready_a, e_a);
            chk("m_ready_b", ready_b, e_b);
            chk("m_regwrite", RegWrite, m_we && !reset);
            chk("m_writereg", WriteRegister, m_addr);
            chk("m_writedata", WriteData, m_data);
            chk("m_conflicts", conflicts, m_conf);
        end
        if (reset) begin
            m_ptr = 0; m_we = 0; m_addr = '0; m_data = '0; m_conf = 0;
        end else begin
            if (e_a) begin
                m_we = (addr_a != 5'd31); m_addr = addr_a; m_data = data_a; m_ptr = 1;
            end else if (e_b) begin
                m_we = (addr_b != 5'd31); m_addr = addr_b; m_data = data_b; m_ptr = 0;
            end else begin
                m_we = 0;
            end
            if (valid_a && valid_b && !stall) m_conf = (m_conf >= 255) ? 255 : m_conf + 1;
        end
    end

    task automatic drv(input bit r, input bit s,
                       input bit va, input logic [4:0] aa, input logic [63:0] da,
                       input bit vb, input logic [4:0] ab, input logic [63:0] db);
        @(negedge clk);
        reset = r; stall = s;
        valid_a = va; addr_a = aa; data_a = da;
        valid_b = vb; addr_b = ab; data_b = db;
    endtask

    task automatic idle();
        drv(0, 0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
    endtask

    bit          pa, pb, ga, gb;
    logic [4:0]  pa_addr, pb_addr;
    logic [63:0] pa_data, pb_data;
    bit          rr, ss;

    initial begin
        reset = 1; stall = 0;
        valid_a = 0; addr_a = '0; data_a = '0;
        valid_b = 0; addr_b = '0; data_b = '0;
        @(posedge clk);
        #1 check_en = 1;

        // reset state
        drv(1, 0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        #3;
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_writereg", WriteRegister, 0);
        chk("rst_writedata", WriteData, 0);
        chk("rst_conflicts", conflicts, 0);

        // single write from A
        drv(0, 0, 1, 5'd3, 64'h1111, 0, 5'd0, 64'd0);
        #3;
        chk("s1_ready_a", ready_a, 1);
        chk("s1_ready_b", ready_b, 0);
        idle();
        #3;
        chk("s1_regwrite", RegWrite, 1);
        chk("s1_writereg", WriteRegister, 3);
        chk("s1_writedata", WriteData, 64'h1111);

        // contention alternates A,B,A,B
        drv(1, 0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 1, 5'(i + 1), 64'hA0 + 64'(i), 1, 5'(i + 10), 64'hB0 + 64'(i));
            #3;
            chk($sformatf("s2_grant%0d", i), {ready_a, ready_b}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        idle();
        #3;
        chk("s2_conflicts", conflicts, 4);
        chk("s2_last_write", WriteData, 64'hB3);

        // stall blocks grants; pointer holder (A) wins afterwards
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 1, 5'd4, 64'h44, 1, 5'd5, 64'h55);
            #3;
            chk($sformatf("s3_stall_ready%0d", i), {ready_a, ready_b}, 2'b00);
            chk($sformatf("s3_stall_regwrite%0d", i), RegWrite, 0);
        end
        drv(0, 0, 1, 5'd4, 64'h44, 1, 5'd5, 64'h55);
        #3;
        chk("s3_unstall_ready_a", ready_a, 1);

        // register 31 is accepted but not written
        drv(0, 0, 0, 5'd0, 64'd0, 1, 5'd31, 64'hDEAD);
        #3;
        chk("s4_ready_b", ready_b, 1);
        idle();
        #3;
        chk("s4_regwrite", RegWrite, 0);
        chk("s4_writedata", WriteData, 64'hDEAD);
        chk("s4_writereg", WriteRegister, 31);

        // contention counter saturates
        for (int i = 0; i < 300; i++) drv(0, 0, 1, 5'd6, 64'(i), 1, 5'd7, 64'(i + 1000));
        idle();
        #3;
        chk("s5_conflicts_sat", conflicts, 255);
        for (int i = 0; i < 5; i++) drv(0, 0, 1, 5'd6, 64'd1, 1, 5'd7, 64'd2);
        idle();
        #3;
        chk("s5_conflicts_hold", conflicts, 255);

        // reset right after a transfer kills the pending write
        drv(0, 0, 1, 5'd7, 64'h77, 0, 5'd0, 64'd0);
        #3;
        chk("s6_xfer_ready_a", ready_a, 1);
        drv(1, 0, 1, 5'd9, 64'h99, 0, 5'd0, 64'd0);
        #3;
        chk("s6_rst_ready_a", ready_a, 0);
        chk("s6_rst_regwrite", RegWrite, 0);
        drv(0, 0, 1, 5'd8, 64'h88, 1, 5'd2, 64'h22);
        #3;
        chk("s6_after_regwrite", RegWrite, 0);
        chk("s6_after_conflicts", conflicts, 0);
        chk("s6_after_ptr_a", {ready_a, ready_b}, 2'b10);
        idle();

        // randomized traffic with handshake-respecting requesters
        pa = 0; pb = 0; ga = 0; gb = 0;
        pa_addr = '0; pb_addr = '0; pa_data = '0; pb_data = '0;
        for (int i = 0; i < 3000; i++) begin
            if (ga) pa = 0;
            if (gb) pb = 0;
            if (!pa && ($urandom % 3 != 0)) begin
                pa = 1;
                pa_addr = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom);
                pa_data = {$urandom, $urandom};
            end
            if (!pb && ($urandom % 3 != 0)) begin
                pb = 1;
                pb_addr = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom);
                pb_data = {$urandom, $urandom};
            end
            ss = ($urandom % 5 == 0);
            rr = ($urandom % 100 == 0);
            drv(rr, ss, pa, pa_addr, pa_data, pb, pb_addr, pb_data);
            #3;
            ga = ready_a;
            gb = ready_b;
        end
        idle();

        @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
